game_ctrl: RTL
==============

Name: game_ctrl

Overview:
- Match-level controller that sits directly beside the ball stage: consumes the ball's `p1_score`/`p2_score` and drives its `game_state` and active-low reset.
- Sequences idle → serve delay → rally → point scored → serve → … → game over, with pause/resume.
- Runs on the system clock.
- Millisecond timing uses a one-cycle `tick_1ms` enable, so the block has no second clock.

Parameters:
- WIN_SCORE, 7, points needed to win; legal range 1..15.
- SERVE_MS, 1000, serve-delay length in `tick_1ms` pulses; must be ≥1.

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- reset  in  1  synchronous, active-low reset (sampled on posedge clk; low → reset)
- tick_1ms  in  1  one-clk-wide pulse every 1 ms, synchronous to clk
- start_btn  in  1  debounced level, clk-synchronous; action on rising edge
- pause_btn  in  1  debounced level, clk-synchronous; action on rising edge
- p1_score  in  4  from ball stage; clk-synchronous, changes at most +1 per tick
- p2_score  in  4  from ball stage; same rules as p1_score
- game_state  out  2  00 idle/over-clear, 01 play, 10 serve/pause, 11 game over
- ball_rst_n  out  1  active-low reset to ball stage (clears ball position and scores)
- paused  out  1  high only in PAUSE
- winner  out  2  00 none, 01 player 1, 10 player 2
- serve_cnt  out  10  remaining serve ms (for HUD); 0 outside SERVE

Behaviour:
- Reset (reset=0 at posedge):
  - state=IDLE, game_state=00, ball_rst_n=1, paused=0, winner=00, serve_cnt=0.
  - Button edge registers cleared; prev-score registers cleared.
  - Reset wins over every other event, including mid-serve and mid-pause.
- Edge detect: `start_rise = start_btn & ~start_q`, likewise `pause_rise`. `_q` registers update every cycle.
- Score change: prev registers sample both scores every cycle; `p1_pt = (p1_score != p1_prev)`, likewise `p2_pt`.
- Internal states and game_state encoding:
  - IDLE → 00
  - CLEAR → 00
  - SERVE → 10
  - PLAY → 01
  - PAUSE → 10
  - OVER → 11
- Transitions:
  - IDLE: start_rise → CLEAR.
  - CLEAR:
    - ball_rst_n=0 while here; winner←00.
    - Leave on the first cycle with tick_1ms=1; that cycle keeps ball_rst_n=0, so the ball stage samples reset.
    - Exit → SERVE with serve counter loaded to SERVE_MS.
  - SERVE:
    - Counter decrements on each tick_1ms.
    - On a tick with counter==1 → PLAY, counter←0.
    - pause_rise and start_rise are ignored here.
  - PLAY:
    - p1_pt or p2_pt, with p1_score≥WIN_SCORE or p2_score≥WIN_SCORE → OVER.
    - p1_pt or p2_pt otherwise → SERVE, counter←SERVE_MS.
    - pause_rise (no point that cycle) → PAUSE.
  - PAUSE: pause_rise → PLAY; start_rise ignored. Scores cannot change while paused because the ball is frozen.
  - OVER:
    - winner set on entry: 01 if p1_score≥WIN_SCORE, else 10.
    - start_rise → CLEAR (new match).
- Simultaneous events:
  - Point and pause_rise in the same PLAY cycle: the point wins, the pause is dropped.
  - Both scores reach WIN_SCORE in the same cycle: winner=01.
- Latency: all outputs are registered.
  - game_state changes the cycle after the triggering input edge or point.
  - A point is reflected one cycle after the score changes.
- serve_cnt: 10 bits; SERVE_MS >1023 is not supported (checked by elaboration assertion).
- Score wrap (15→0) is impossible because OVER is reached at WIN_SCORE≤15. If observed, it is treated as a point.

Decomposition:
- Shared package `pong_pkg`:
  - game_state encodings GS_IDLE=00, GS_PLAY=01, GS_HOLD=10, GS_OVER=11.
  - winner encodings.
  - H_ACTIVE/V_ACTIVE and paddle/ball geometry, used by the ball, paddle and renderer blocks.
- Internal state enum stays local.
- One sub-module, `edge_rise` (1-bit registered rising-edge detector), instantiated twice.

Test Plan:
1. Reset low 3 cycles, release.
   → game_state=00, ball_rst_n=1, winner=00.
   Pulse start.
   → CLEAR; ball_rst_n=0 until the first tick, then SERVE with serve_cnt=1000.
   After 1000 ticks → game_state=01.
2. SERVE_MS=3. In PLAY, step p2_score 0→1.
   → next cycle game_state=10, serve_cnt=3; after 3 ticks → 01.
3. WIN_SCORE=7. Step p1_score 6→7 in PLAY.
   → game_state=11, winner=01.
   Start pulse → CLEAR, ball_rst_n=0, winner=00.
4. In PLAY, pulse pause.
   → game_state=10, paused=1.
   Pulse start → no change.
   Pulse pause → 01, paused=0.
5. Same cycle: p1_score 2→3 and pause rise.
   → SERVE (paused=0).
   Separately, p1 and p2 both step 6→7 in one cycle → OVER, winner=01.
6. Assert reset mid-SERVE (serve_cnt=500).
   → next cycle IDLE, serve_cnt=0, game_state=00; ticks without start keep IDLE.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared definitions for the pong blocks: game_state and winner encodings
// exchanged between the match controller and the ball stage, plus the
// screen and object geometry used by the ball, paddle and renderer blocks.
package pong_pkg;

   localparam logic [1:0] GS_IDLE = 2'b00;
   localparam logic [1:0] GS_PLAY = 2'b01;
   localparam logic [1:0] GS_HOLD = 2'b10;
   localparam logic [1:0] GS_OVER = 2'b11;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;

   localparam int H_ACTIVE  = 640;
   localparam int V_ACTIVE  = 480;
   localparam int PADDLE_W  = 8;
   localparam int PADDLE_H  = 64;
   localparam int PADDLE_X1 = 16;
   localparam int PADDLE_X2 = H_ACTIVE - 16 - PADDLE_W;
   localparam int BALL_SIZE = 8;

endpackage

// File: rtl/edge_rise.sv
// One-bit rising-edge detector with a registered history bit.
// Ports: clk, reset (sync, active-low), i_d level in, o_rise high for the
// cycle in which i_d is 1 and was 0 on the previous cycle.
module edge_rise (
   input  logic clk,
   input  logic reset,
   input  logic i_d,
   output logic o_rise
);

   logic r_q;

   always_ff @(posedge clk) begin
      if (!reset) r_q <= 1'b0;
      else        r_q <= i_d;
   end

   assign o_rise = i_d & ~r_q;

endmodule

// File: rtl/game_ctrl.sv
// Match-level controller for the pong ball stage. Sequences a match through
// serve delay, rally, point, serve ... game over, with pause/resume.
// Ports: clk, reset (sync, active-low), tick_1ms (1 ms enable pulse),
// start_btn / pause_btn (levels, act on rising edge), p1_score / p2_score
// (from ball stage), game_state, ball_rst_n (active-low ball reset),
// paused, winner, serve_cnt (remaining serve ms, 0 outside SERVE).
//
// state  | meaning
// IDLE   | waiting for first start press after reset
// CLEAR  | holding ball stage in reset until the next ms tick
// SERVE  | counting down the serve delay
// PLAY   | rally in progress, watching for points and pause
// PAUSE  | ball frozen until the next pause press
// OVER   | match finished, winner shown until start
module game_ctrl
   import pong_pkg::*;
#(
   parameter int WIN_SCORE = 7,
   parameter int SERVE_MS  = 1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick_1ms,
   input  logic       start_btn,
   input  logic       pause_btn,
   input  logic [3:0] p1_score,
   input  logic [3:0] p2_score,
   output logic [1:0] game_state,
   output logic       ball_rst_n,
   output logic       paused,
   output logic [1:0] winner,
   output logic [9:0] serve_cnt
);

   if (SERVE_MS < 1 || SERVE_MS > 1023) begin : g_bad_serve_ms
      $error("game_ctrl: SERVE_MS must be 1..1023");
   end
   if (WIN_SCORE < 1 || WIN_SCORE > 15) begin : g_bad_win_score
      $error("game_ctrl: WIN_SCORE must be 1..15");
   end

   localparam logic [9:0] SERVE_LD = 10'(SERVE_MS);
   localparam logic [3:0] WIN_PTS  = 4'(WIN_SCORE);

   typedef enum logic [2:0] {
      ST_IDLE, ST_CLEAR, ST_SERVE, ST_PLAY, ST_PAUSE, ST_OVER
   } state_t;

   state_t     r_state, w_state_nxt;
   logic [9:0] r_cnt, w_cnt_nxt;
   logic [1:0] r_winner, w_winner_nxt;
   logic [1:0] r_gs;
   logic       r_ball_rst_n;
   logic       r_paused;
   logic [3:0] r_p1_prev, r_p2_prev;

   logic w_start_rise, w_pause_rise;
   logic w_point, w_p1_win, w_p2_win;

   edge_rise u_start_edge (
      .clk   (clk),
      .reset (reset),
      .i_d   (start_btn),
      .o_rise(w_start_rise)
   );

   edge_rise u_pause_edge (
      .clk   (clk),
      .reset (reset),
      .i_d   (pause_btn),
      .o_rise(w_pause_rise)
   );

   // Any change counts as a point, including an unexpected 15->0 wrap.
   assign w_point  = (p1_score != r_p1_prev) | (p2_score != r_p2_prev);
   assign w_p1_win = (p1_score >= WIN_PTS);
   assign w_p2_win = (p2_score >= WIN_PTS);

   function automatic logic [1:0] gs_of(input state_t s);
      case (s)
         ST_SERVE, ST_PAUSE: gs_of = GS_HOLD;
         ST_PLAY:            gs_of = GS_PLAY;
         ST_OVER:            gs_of = GS_OVER;
         default:            gs_of = GS_IDLE;
      endcase
   endfunction

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = '0;
      w_winner_nxt = r_winner;
      case (r_state)
         ST_IDLE: begin
            if (w_start_rise) begin
               w_state_nxt  = ST_CLEAR;
               w_winner_nxt = WIN_NONE;
            end
         end
         ST_CLEAR: begin
            w_winner_nxt = WIN_NONE;
            if (tick_1ms) begin
               w_state_nxt = ST_SERVE;
               w_cnt_nxt   = SERVE_LD;
            end
         end
         ST_SERVE: begin
            w_cnt_nxt = r_cnt;
            if (tick_1ms) begin
               if (r_cnt == 10'd1) begin
                  w_state_nxt = ST_PLAY;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt - 10'd1;
               end
            end
         end
         ST_PLAY: begin
            // A point in the same cycle as a pause press drops the pause.
            if (w_point) begin
               if (w_p1_win || w_p2_win) begin
                  w_state_nxt  = ST_OVER;
                  w_winner_nxt = w_p1_win ? WIN_P1 : WIN_P2;
               end else begin
                  w_state_nxt = ST_SERVE;
                  w_cnt_nxt   = SERVE_LD;
               end
            end else if (w_pause_rise) begin
               w_state_nxt = ST_PAUSE;
            end
         end
         ST_PAUSE: begin
            if (w_pause_rise) w_state_nxt = ST_PLAY;
         end
         ST_OVER: begin
            if (w_start_rise) begin
               w_state_nxt  = ST_CLEAR;
               w_winner_nxt = WIN_NONE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_winner     <= WIN_NONE;
         r_gs         <= GS_IDLE;
         r_ball_rst_n <= 1'b1;
         r_paused     <= 1'b0;
         r_p1_prev    <= '0;
         r_p2_prev    <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_winner     <= w_winner_nxt;
         r_gs         <= gs_of(w_state_nxt);
         r_ball_rst_n <= (w_state_nxt != ST_CLEAR);
         r_paused     <= (w_state_nxt == ST_PAUSE);
         r_p1_prev    <= p1_score;
         r_p2_prev    <= p2_score;
      end
   end

   assign game_state = r_gs;
   assign ball_rst_n = r_ball_rst_n;
   assign paused     = r_paused;
   assign winner     = r_winner;
   assign serve_cnt  = r_cnt;

endmodule
